// File: rtl/fp_pkg.sv
// Shared constants and encodings for the FPCalculator binary64 <-> int64 converters.
package fp_pkg;

    localparam int DP_BIAS   = 1023;
    localparam int DP_EXP_W  = 11;
    localparam int DP_FRAC_W = 52;

    localparam logic [63:0] INT64_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;

    localparam logic [DP_EXP_W-1:0] EXP_ALL_ONES = '1;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        SHIFT,
        ROUND,
        DONE
    } conv_state_t;

    typedef enum logic [2:0] {
        ZERO,
        SUBNORM,
        NORMAL,
        INF,
        NAN
    } fp_class_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational binary64 field split, classification and int64 range decision.
// Special operands come out with their final int64 result already chosen.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [63:0]          fp,
    output logic                 sign,
    output logic [DP_FRAC_W:0]   mag,
    output logic                 special,
    output logic [63:0]          special_val,
    output logic                 special_invalid,
    output logic                 special_inexact,
    output logic                 shift_left,
    output logic [6:0]           shift_dist
);

    logic [DP_EXP_W-1:0]        exp_field;
    logic [DP_FRAC_W-1:0]       frac;
    fp_class_t                  cls;
    logic signed [DP_EXP_W+1:0] exp_unb;
    logic signed [DP_EXP_W+1:0] left_dist;
    logic signed [DP_EXP_W+1:0] right_dist;
    logic                       is_int64_min;
    logic [63:0]                sat_val;

    assign sign       = fp[63];
    assign exp_field  = fp[62:52];
    assign frac       = fp[51:0];
    assign mag        = {1'b1, frac};
    assign exp_unb    = $signed({2'b00, exp_field}) - $signed(13'(DP_BIAS));
    assign left_dist  = exp_unb - $signed(13'(DP_FRAC_W));
    assign right_dist = $signed(13'(DP_FRAC_W)) - exp_unb;
    assign sat_val    = sign ? INT64_MIN : INT64_MAX;

    always_comb begin
        cls = NORMAL;
        if (exp_field == '0) begin
            if (frac == '0) cls = ZERO;
            else            cls = SUBNORM;
        end else if (exp_field == EXP_ALL_ONES) begin
            if (frac == '0) cls = INF;
            else            cls = NAN;
        end
    end

    // -2^63 is the only e=63 value that is representable.
    assign is_int64_min = sign && (exp_unb == 13'sd63) && (frac == '0);

    always_comb begin
        special         = 1'b1;
        special_val     = '0;
        special_invalid = 1'b0;
        special_inexact = 1'b0;
        shift_left      = 1'b0;
        shift_dist      = '0;
        case (cls)
            ZERO: begin
                special_val = '0;
            end
            SUBNORM: begin
                special_inexact = 1'b1;
            end
            INF: begin
                special_val     = sat_val;
                special_invalid = 1'b1;
            end
            NAN: begin
                special_val     = INT64_MAX;
                special_invalid = 1'b1;
            end
            default: begin
                if (is_int64_min) begin
                    special_val = INT64_MIN;
                end else if (exp_unb >= 13'sd63) begin
                    special_val     = sat_val;
                    special_invalid = 1'b1;
                end else begin
                    special = 1'b0;
                    if (exp_unb >= 13'sd52) begin
                        shift_left = 1'b1;
                        shift_dist = 7'(left_dist);
                    end else if (right_dist > 13'sd64) begin
                        shift_dist = 7'd64;
                    end else begin
                        shift_dist = 7'(right_dist);
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_to_int.sv
// Iterative binary64 -> signed int64 converter, round-to-nearest-even, saturating.
// The significand is shifted at most SHIFT_STEP bits per cycle instead of in one barrel shift.
module fp_to_int
    import fp_pkg::*;
#(
    parameter int SHIFT_STEP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] fp_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] int_out,
    output logic        flag_invalid,
    output logic        flag_inexact,
    output logic [2:0]  dbg_state
);

    localparam logic [6:0] STEP = 7'(SHIFT_STEP);

    conv_state_t state;
    logic [63:0] op_q;
    logic [63:0] acc;
    logic [6:0]  remaining;
    logic        dir_left;
    logic        guard;
    logic        sticky;
    logic        sign_q;
    logic        special_q;
    logic        spec_invalid_q;
    logic        spec_inexact_q;

    logic        u_sign;
    logic [52:0] u_mag;
    logic        u_special;
    logic [63:0] u_special_val;
    logic        u_special_invalid;
    logic        u_special_inexact;
    logic        u_shift_left;
    logic [6:0]  u_shift_dist;

    logic [6:0]  step;
    logic [63:0] low_mask;
    logic [63:0] guard_word;
    logic        step_guard;
    logic        step_sticky;
    logic        round_up;
    logic [63:0] rounded;
    logic [63:0] signed_res;

    fp_unpack u_unpack (
        .fp              (op_q),
        .sign            (u_sign),
        .mag             (u_mag),
        .special         (u_special),
        .special_val     (u_special_val),
        .special_invalid (u_special_invalid),
        .special_inexact (u_special_inexact),
        .shift_left      (u_shift_left),
        .shift_dist      (u_shift_dist)
    );

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and int_out/flags stay frozen while out_valid is high.
    assign in_ready  = (state == IDLE);
    assign dbg_state = state;

    // Right shifts: the top bit leaving acc becomes guard, everything older folds into sticky.
    always_comb begin
        step        = (remaining < STEP) ? remaining : STEP;
        guard_word  = acc >> (step - 7'd1);
        step_guard  = guard_word[0];
        low_mask    = (64'd1 << (step - 7'd1)) - 64'd1;
        step_sticky = |(acc & low_mask);
    end

    always_comb begin
        round_up   = guard & (sticky | acc[0]);
        rounded    = acc + {63'd0, round_up};
        signed_res = sign_q ? (64'd0 - rounded) : rounded;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            op_q           <= '0;
            acc            <= '0;
            remaining      <= '0;
            dir_left       <= 1'b0;
            guard          <= 1'b0;
            sticky         <= 1'b0;
            sign_q         <= 1'b0;
            special_q      <= 1'b0;
            spec_invalid_q <= 1'b0;
            spec_inexact_q <= 1'b0;
            out_valid      <= 1'b0;
            int_out        <= '0;
            flag_invalid   <= 1'b0;
            flag_inexact   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= fp_in;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_q         <= u_sign;
                    special_q      <= u_special;
                    spec_invalid_q <= u_special_invalid;
                    spec_inexact_q <= u_special_inexact;
                    guard          <= 1'b0;
                    sticky         <= 1'b0;
                    dir_left       <= u_shift_left;
                    remaining      <= u_shift_dist;
                    if (u_special) begin
                        acc   <= u_special_val;
                        state <= ROUND;
                    end else begin
                        acc   <= {11'd0, u_mag};
                        state <= (u_shift_dist == '0) ? ROUND : SHIFT;
                    end
                end
                SHIFT: begin
                    if (dir_left) begin
                        acc <= acc << step;
                    end else begin
                        acc    <= acc >> step;
                        guard  <= step_guard;
                        sticky <= sticky | guard | step_sticky;
                    end
                    remaining <= remaining - step;
                    if (remaining == step) state <= ROUND;
                end
                ROUND: begin
                    if (special_q) begin
                        int_out      <= acc;
                        flag_invalid <= spec_invalid_q;
                        flag_inexact <= spec_inexact_q;
                    end else begin
                        int_out      <= signed_res;
                        flag_invalid <= 1'b0;
                        flag_inexact <= guard | sticky;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_int.sv
// Bench for fp_to_int: directed plan cases plus randomized operands checked
// against a real-arithmetic reference of round-to-nearest-even conversion.
module tb_fp_to_int;
    import fp_pkg::*;

    localparam int STEP = 16;

    logic        tb_clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] fp_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] int_out;
    logic        flag_invalid;
    logic        flag_inexact;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [65:0] exp_q[$];

    fp_to_int #(.SHIFT_STEP(STEP)) dut (
        .clk          (tb_clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fp_in        (fp_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .int_out      (int_out),
        .flag_invalid (flag_invalid),
        .flag_inexact (flag_inexact),
        .dbg_state    (dbg_state)
    );

    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // {invalid, inexact, result} from the numeric value of the operand.
    function automatic logic [65:0] ref_model(input logic [63:0] op);
        real    x, ax, fl, fr;
        longint li;
        logic   inexact;
        if (op[62:52] == 11'h7FF) begin
            if (op[51:0] != '0) return {2'b10, INT64_MAX};
            return {2'b10, (op[63] ? INT64_MIN : INT64_MAX)};
        end
        x  = $bitstoreal(op);
        ax = (x < 0.0) ? -x : x;
        if (x == -9223372036854775808.0) return {2'b00, INT64_MIN};
        if (ax >= 9223372036854775808.0) return {2'b10, (op[63] ? INT64_MIN : INT64_MAX)};
        fl = $floor(ax);
        fr = ax - fl;
        li = longint'(fl);
        if (fr > 0.5 || (fr == 0.5 && li[0])) li = li + 64'sd1;
        if (op[63]) li = -li;
        inexact = (fr != 0.0);
        return {1'b0, inexact, li};
    endfunction

    function automatic int ref_latency(input logic [63:0] op);
        int e, d;
        e = int'(op[62:52]) - 1023;
        if (op[62:52] == 11'h000 || op[62:52] == 11'h7FF || e >= 63) return 3;
        d = (e >= 52) ? e - 52 : 52 - e;
        if (d > 64) d = 64;
        return 3 + (d + STEP - 1) / STEP;
    endfunction

    task automatic convert(input logic [63:0] op, input int hold);
        logic [65:0] expv;
        int          exp_n;
        int          n;
        exp_q.push_back(ref_model(op));
        exp_n = ref_latency(op);
        check($sformatf("in_ready_idle %h", op), {63'd0, in_ready}, 64'd1);
        out_ready = (hold == 0);
        fp_in     = op;
        in_valid  = 1'b1;
        @(posedge tb_clk); #1;
        in_valid = 1'b0;
        fp_in    = {$urandom, $urandom};
        check($sformatf("in_ready_busy %h", op), {63'd0, in_ready}, 64'd0);
        n = 0;
        while (!out_valid && n < 64) begin
            @(posedge tb_clk); #1;
            n++;
        end
        check($sformatf("latency %h", op), 64'(n), 64'(exp_n));
        expv = exp_q.pop_front();
        check($sformatf("result %h", op), int_out, expv[63:0]);
        check($sformatf("invalid %h", op), {63'd0, flag_invalid}, {63'd0, expv[65]});
        check($sformatf("inexact %h", op), {63'd0, flag_inexact}, {63'd0, expv[64]});
        for (int k = 0; k < hold; k++) begin
            @(posedge tb_clk); #1;
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_result", int_out, expv[63:0]);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge tb_clk); #1;
        check($sformatf("valid_drop %h", op), {63'd0, out_valid}, 64'd0);
        check($sformatf("in_ready_back %h", op), {63'd0, in_ready}, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_int_out"}, int_out, 64'd0);
        check({tag, "_invalid"}, {63'd0, flag_invalid}, 64'd0);
        check({tag, "_inexact"}, {63'd0, flag_inexact}, 64'd0);
        check({tag, "_state"}, {61'd0, dbg_state}, 64'(IDLE));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        fp_in     = '0;
        repeat (2) @(posedge tb_clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge tb_clk); #1;

        convert(64'h3FF0000000000000, 0);
        convert(64'h4004000000000000, 0);
        convert(64'h400C000000000000, 0);
        convert(64'hBFF8000000000000, 0);
        convert(64'hBFE0000000000000, 0);
        convert(64'hC3E0000000000000, 0);
        convert(64'h43E0000000000000, 0);
        convert(64'h7FF8000000000000, 0);
        convert(64'hFFF0000000000000, 0);
        convert(64'h8000000000000000, 0);
        convert(64'h0000000000000001, 0);
        convert(64'h3C00000000000000, 0);
        convert(64'h4330000000000000, 10);

        // Reset while the shifter is busy; previous result is nonzero.
        fp_in    = 64'h3FF0000000000000;
        in_valid = 1'b1;
        @(posedge tb_clk); #1;
        in_valid = 1'b0;
        @(posedge tb_clk); #1;
        check("mid_state_shift", {61'd0, dbg_state}, 64'(SHIFT));
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge tb_clk);
        rst = 1'b0;
        @(posedge tb_clk); #1;
        convert(64'h4014000000000000, 0);

        for (int i = 0; i < 160; i++) begin
            logic [63:0] op;
            logic [63:0] r64;
            logic [51:0] f;
            logic        s;
            int          ex;
            int          sh;
            r64 = {$urandom, $urandom};
            f   = r64[51:0];
            s   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: op = {$urandom, $urandom};
                1: begin
                    ex = $urandom_range(1017, 1090);
                    op = {s, 11'(ex), f};
                end
                2: begin
                    ex = $urandom_range(1022, 1035);
                    sh = 51 - (ex - 1023);
                    f  = (f >> sh) << sh;
                    op = {s, 11'(ex), f};
                end
                3: begin
                    ex = $urandom_range(1083, 1087);
                    if ($urandom_range(0, 1) == 0) f = '0;
                    op = {s, 11'(ex), f};
                end
                default: begin
                    case ($urandom_range(0, 4))
                        0: op = {s, 63'd0};
                        1: op = {s, 11'd0, f | 52'd1};
                        2: op = {s, 11'h7FF, 52'd0};
                        3: op = {s, 11'h7FF, f | 52'd1};
                        default: op = 64'hC3E0000000000000;
                    endcase
                end
            endcase
            convert(op, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
